// File: rtl/alb_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic ops, iterative shift-add multiply,
// registered result and flags, carry register for chained ADC/SBC.
module alb_mc #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic [2:0]       ALB_MI,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] F,
    output logic             CO,
    output logic             VO,
    output logic             NO,
    output logic             ZO,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds its data while valid && !ready; ready never depends on valid.

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]   a_reg, a_n;
    logic [WIDTH-1:0]   b_reg, b_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               c_reg, c_n;
    logic [WIDTH-1:0]   f_n;
    logic               co_n, vo_n, no_n, zo_n, ov_n;

    logic               accept;
    logic [WIDTH-1:0]   b_op;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_f;
    logic               alu_co, alu_vo;
    logic [2*WIDTH-1:0] addend, acc_sum;
    logic               last;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_f;
    logic               wr_co, wr_vo;

    assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == S_MUL);
    assign dbg_state = state;

    // Single-cycle datapath; subtract variants share the adder with B inverted.
    always_comb begin
        b_op   = ((ALB_MI == OP_SUB) || (ALB_MI == OP_SBC)) ? ~B : B;
        cin    = 1'b0;
        alu_f  = '0;
        alu_co = 1'b0;
        alu_vo = 1'b0;
        case (ALB_MI)
            OP_ADD:  cin = CI;
            OP_SUB:  cin = 1'b1;
            default: cin = c_reg;
        endcase
        sum = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        case (ALB_MI)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_f  = sum[WIDTH-1:0];
                alu_co = sum[WIDTH];
                alu_vo = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_f = A & B;
            OP_OR:   alu_f = A | B;
            OP_XOR:  alu_f = A ^ B;
            default: alu_f = '0;
        endcase
    end

    // One multiplier bit per cycle; the last iteration's sum is the final product.
    assign addend  = b_reg[cnt] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
    assign acc_sum = acc + addend;
    assign last    = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        b_n     = b_reg;
        acc_n   = acc;
        cnt_n   = cnt;
        ov_n    = out_valid;
        wr_en   = 1'b0;
        wr_f    = '0;
        wr_co   = 1'b0;
        wr_vo   = 1'b0;
        case (state)
            S_RUN: begin
                if (accept) begin
                    if (ALB_MI == OP_MUL) begin
                        a_n     = A;
                        b_n     = B;
                        acc_n   = '0;
                        cnt_n   = '0;
                        ov_n    = 1'b0;
                        state_n = S_MUL;
                    end else begin
                        wr_en = 1'b1;
                        wr_f  = alu_f;
                        wr_co = alu_co;
                        wr_vo = alu_vo;
                        ov_n  = 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    ov_n = 1'b0;
                end
            end
            S_MUL: begin
                acc_n = acc_sum;
                cnt_n = cnt + CW'(1);
                if (last) begin
                    wr_en   = 1'b1;
                    wr_f    = acc_sum[WIDTH-1:0];
                    wr_co   = |acc_sum[2*WIDTH-1:WIDTH];
                    ov_n    = 1'b1;
                    state_n = S_RUN;
                end
            end
            default: state_n = S_RUN;
        endcase
        f_n  = wr_en ? wr_f : F;
        co_n = wr_en ? wr_co : CO;
        vo_n = wr_en ? wr_vo : VO;
        no_n = wr_en ? wr_f[WIDTH-1] : NO;
        zo_n = wr_en ? (wr_f == '0) : ZO;
        c_n  = wr_en ? wr_co : c_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            c_reg     <= 1'b0;
            F         <= '0;
            CO        <= 1'b0;
            VO        <= 1'b0;
            NO        <= 1'b0;
            ZO        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            a_reg     <= a_n;
            b_reg     <= b_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            c_reg     <= c_n;
            F         <= f_n;
            CO        <= co_n;
            VO        <= vo_n;
            NO        <= no_n;
            ZO        <= zo_n;
            out_valid <= ov_n;
        end
    end

endmodule

// File: tb/tb_alb_mc.sv
// Directed bench for alb_mc (WIDTH=10): hand-computed results and flags per scenario.
module tb_alb_mc;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         CI = 1'b0;
    logic [2:0]   ALB_MI = 3'b000;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] F;
    logic         CO, VO, NO, ZO;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    alb_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .CI(CI), .ALB_MI(ALB_MI),
        .in_valid(in_valid), .in_ready(in_ready), .F(F), .CO(CO), .VO(VO),
        .NO(NO), .ZO(ZO), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
        ALB_MI   = op;
        A        = a;
        B        = b;
        CI       = ci;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO, out_valid, busy, dbg_state, in_ready} !== {10'd0, 7'b0000000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset got F=%b flags=%b ov=%b busy=%b st=%b rdy=%b exp all 0, rdy=1",
                     F, {CO, VO, NO, ZO}, out_valid, busy, dbg_state, in_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_sub();
        drive(3'b000, 10'b0110001110, 10'b1010010111, 1'b0);
        step();
        n_checks++;
        if ({out_valid, F, CO, VO, NO, ZO} !== {1'b1, 10'b0000100101, 4'b1000}) begin
            n_fail++;
            $display("FAIL add got ov=%b F=%b cvnz=%b exp 1 0000100101 1000", out_valid, F, {CO, VO, NO, ZO});
        end
        drive(3'b001, 10'b0110001110, 10'b1010010111, 1'b1);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'b1011110111, 4'b0110}) begin
            n_fail++;
            $display("FAIL sub got F=%b cvnz=%b exp 1011110111 0110", F, {CO, VO, NO, ZO});
        end
        drive(3'b011, 10'd5, 10'd3, 1'b0);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'd1, 4'b1000}) begin
            n_fail++;
            $display("FAIL sbc_after_sub got F=%b cvnz=%b exp 0000000001 1000", F, {CO, VO, NO, ZO});
        end
        drive(3'b000, 10'b0111111111, 10'd0, 1'b1);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'b1000000000, 4'b0110}) begin
            n_fail++;
            $display("FAIL add_ci_ovf got F=%b cvnz=%b exp 1000000000 0110", F, {CO, VO, NO, ZO});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_carry_logic();
        drive(3'b000, 10'b1111111111, 10'b0000000001, 1'b0);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'd0, 4'b1001}) begin
            n_fail++;
            $display("FAIL add_wrap got F=%b cvnz=%b exp 0000000000 1001", F, {CO, VO, NO, ZO});
        end
        drive(3'b010, 10'd0, 10'd0, 1'b0);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'd1, 4'b0000}) begin
            n_fail++;
            $display("FAIL adc_chain got F=%b cvnz=%b exp 0000000001 0000", F, {CO, VO, NO, ZO});
        end
        drive(3'b000, 10'b1111111111, 10'b0000000001, 1'b0);
        step();
        drive(3'b100, 10'b1111111111, 10'b1010101010, 1'b1);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'b1010101010, 4'b0010}) begin
            n_fail++;
            $display("FAIL and got F=%b cvnz=%b exp 1010101010 0010", F, {CO, VO, NO, ZO});
        end
        drive(3'b010, 10'd0, 10'd0, 1'b0);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL adc_after_logic got F=%b cvnz=%b exp 0000000000 0001", F, {CO, VO, NO, ZO});
        end
        drive(3'b101, 10'b0000011110, 10'b0101000001, 1'b0);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'b0101011111, 4'b0000}) begin
            n_fail++;
            $display("FAIL or got F=%b cvnz=%b exp 0101011111 0000", F, {CO, VO, NO, ZO});
        end
        drive(3'b110, 10'b1111100000, 10'b1010101010, 1'b0);
        step();
        n_checks++;
        if ({F, CO, VO, NO, ZO} !== {10'b0101001010, 4'b0000}) begin
            n_fail++;
            $display("FAIL xor got F=%b cvnz=%b exp 0101001010 0000", F, {CO, VO, NO, ZO});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_f, input logic [3:0] exp_flags);
        int cyc;
        drive(3'b111, a, b, 1'b0);
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            n_checks++;
            if ({busy, in_ready, dbg_state} !== 3'b101) begin
                n_fail++;
                $display("FAIL mul_busy cyc=%0d got busy=%b rdy=%b st=%b exp 1 0 1", cyc, busy, in_ready, dbg_state);
            end
            step();
            cyc++;
        end
        n_checks++;
        if (cyc !== W) begin
            n_fail++;
            $display("FAIL mul_latency got %0d cycles exp %0d", cyc, W);
        end
        n_checks++;
        if ({out_valid, busy, in_ready, F, CO, VO, NO, ZO} !== {3'b101, exp_f, exp_flags}) begin
            n_fail++;
            $display("FAIL mul_result got ov=%b busy=%b rdy=%b F=%b cvnz=%b exp 1 0 1 %b %b",
                     out_valid, busy, in_ready, F, {CO, VO, NO, ZO}, exp_f, exp_flags);
        end
        step();
    endtask

    task automatic test_mul();
        run_mul(10'd3, 10'd5, 10'b0000001111, 4'b0000);
        run_mul(10'b1000000000, 10'b0000000010, 10'd0, 4'b1001);
        run_mul(10'b1111111111, 10'b1111111111, 10'd1, 4'b1000);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic [W-1:0] vf [4];
        logic [3:0]   vflg [4];
        va[0] = 10'd1;    vb[0] = 10'd2;   vf[0] = 10'd3;   vflg[0] = 4'b0000;
        va[1] = 10'd100;  vb[1] = 10'd200; vf[1] = 10'd300; vflg[1] = 4'b0000;
        va[2] = 10'd1000; vb[2] = 10'd30;  vf[2] = 10'd6;   vflg[2] = 4'b1000;
        va[3] = 10'd512;  vb[3] = 10'd512; vf[3] = 10'd0;   vflg[3] = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, va[i], vb[i], 1'b0);
            step();
            n_checks++;
            if ({in_ready, out_valid, F, CO, VO, NO, ZO} !== {2'b11, vf[i], vflg[i]}) begin
                n_fail++;
                $display("FAIL b2b[%0d] got rdy=%b ov=%b F=%b cvnz=%b exp 1 1 %b %b",
                         i, in_ready, out_valid, F, {CO, VO, NO, ZO}, vf[i], vflg[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain got ov=%b exp 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'b000, 10'd5, 10'd6, 1'b0);
        step();
        drive(3'b001, 10'd20, 10'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({out_valid, in_ready, F, CO, VO, NO, ZO} !== {2'b10, 10'd11, 4'b0000}) begin
                n_fail++;
                $display("FAIL hold[%0d] got ov=%b rdy=%b F=%b cvnz=%b exp 1 0 0000001011 0000",
                         i, out_valid, in_ready, F, {CO, VO, NO, ZO});
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready got %b exp 1", in_ready);
        end
        step();
        n_checks++;
        if ({out_valid, F, CO, VO, NO, ZO} !== {1'b1, 10'd17, 4'b1000}) begin
            n_fail++;
            $display("FAIL release_accept got ov=%b F=%b cvnz=%b exp 1 0000010001 1000", out_valid, F, {CO, VO, NO, ZO});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        drive(3'b111, 10'd3, 10'd5, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({F, CO, VO, NO, ZO, out_valid, busy, dbg_state, in_ready} !== {10'd0, 7'b0000000, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_abort got F=%b flags=%b ov=%b busy=%b st=%b rdy=%b exp all 0, rdy=1",
                     F, {CO, VO, NO, ZO}, out_valid, busy, dbg_state, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mul_abort_quiet got %0d active cycles exp 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_carry_logic();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
